_5bit_xor_stream: RTL
=====================

# _5bit_xor_stream

Registered, handshaked wrapper stage around the combinational `_5bit_xor` datapath. It accepts operand pairs (a, b) over a valid/ready interface and presents each registered 5-bit XOR result downstream, together with its parity. It also keeps a running XOR checksum and a transfer count of every result consumed. It sits between the operand source and any result consumer, giving the bare XOR a one-cycle, back-pressurable pipeline slot.

## Interface
Parameters:
- WIDTH, 5, operand/result width (fixed at 5 for this project; parameterised for the package constant)
- CNT_W, 8, width of the transfer counter

Ports:
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- clear  input  1  synchronous; zeroes acc and count on next edge
- in_valid  input  1  operand pair on a/b is valid
- in_ready  output  1  stage can accept an operand pair this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- out_valid  output  1  sum/parity hold a valid result
- out_ready  input  1  consumer accepts result this cycle
- sum  output  WIDTH  registered a ^ b
- parity  output  1  ^sum (XOR-reduction of registered sum)
- acc  output  WIDTH  running XOR of all consumed results since reset/clear
- count  output  CNT_W  number of consumed results since reset/clear, wrapping

## Operation
- FSM states: EMPTY (no held result) and FULL (result held, out_valid=1).
- in_ready = (state==EMPTY) | out_ready; this is combinational and does not depend on in_valid.
- Input transfer: in_valid & in_ready at an edge loads sum <= a ^ b (computed by the `_5bit_xor` instance) and sets state to FULL.
- Output transfer: out_valid & out_ready at an edge updates acc <= acc ^ sum and count <= count + 1, modulo 2^CNT_W, so 255 wraps to 0.
- Transitions:
  - EMPTY, input transfer → FULL.
  - FULL, output transfer and no input transfer → EMPTY.
  - FULL, output and input transfer in the same cycle → stays FULL with the new sum loaded. This gives back-to-back throughput of one result per cycle.
  - FULL, out_ready=0 → hold; sum, parity and out_valid stay stable. in_ready=0.
- clear has priority over accumulation: if clear=1, acc and count become 0 regardless of an output transfer in that cycle. The result is still consumed; it is simply not accumulated. clear does not affect state, sum or handshakes.
- in_valid while in_ready=0 is ignored. The operands are not captured.

## Timing
- Latency: an operand pair accepted at edge N appears on sum with out_valid=1 immediately after edge N, so it is available in cycle N+1.
- parity is combinational from the sum register and has the same timing as sum.
- acc and count reflect a consumed result after the edge at which the transfer occurred.
- Reset values, applied asynchronously on reset=1 and held while asserted: state=EMPTY, out_valid=0, sum=0, parity=0, acc=0, count=0. in_ready=1 after reset.
- Reset mid-operation: a held, unconsumed result is discarded. No partial acc/count update occurs.
- First edge after reset deasserts behaves as a normal EMPTY-state edge.

## Structure
- Shared package/include holds the WIDTH default (5), the CNT_W default (8), and the FSM state encoding (EMPTY=1'b0, FULL=1'b1).
- One sub-module is natural: instantiate the existing `_5bit_xor` (sum, a, b) for the datapath rather than re-coding the XOR. Everything else is local registers plus the FSM.

## Test plan
- Single transfer: after reset, a=00011, b=00010, in_valid=1 for one cycle, out_ready=1. Required response: next cycle sum=00001, parity=1, out_valid=1. The following cycle: out_valid=0, acc=00001, count=1.
- Back-pressure: with out_ready=0, load a=01100, b=01110 (sum=00010). Then drive a=11111, b=00000 with in_valid=1. Required response: in_ready=0, and sum stays 00010 for 3 held cycles. After out_ready=1 for one cycle, acc=00010 and count=1.
- Streaming: in_valid=out_ready=1 for 4 cycles with pairs (00001,00001), (00111,00000), (00001,00100), (01010,10001). Required response: sums 00000, 00111, 00101, 11011, one per cycle with no bubbles. Final acc=11001, count=4.
- Counter wrap: consume 256 results of (00001,00000). Required response: count returns to 0, acc=00000 (even number of 00001 terms).
- clear collision: with acc=00111 and a result 00101 being consumed in the same cycle as clear=1. Required response: acc=0, count=0, out_valid drops to 0 (state EMPTY).
- Async reset mid-hold: state FULL with sum=11011 and out_ready=0; pulse reset between clock edges. Required response: out_valid=0, sum=0, acc=0, count=0 immediately, without waiting for a clock edge; in_ready=1.

Source files
------------

// File: rtl/_5bit_xor_stream_pkg.sv
// Shared constants and FSM encoding for the handshaked 5-bit XOR stage.
package _5bit_xor_stream_pkg;

  localparam int WIDTH_DEF = 5;
  localparam int CNT_W_DEF = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/_5bit_xor_stream_xor.sv
// Combinational XOR datapath; the width is parameterised so the wrapper can pass its package constant.
module _5bit_xor #(
  parameter int WIDTH = 5
) (
  output logic [WIDTH-1:0] sum,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b
);

  assign sum = a ^ b;

endmodule

// File: rtl/_5bit_xor_stream.sv
// One-slot valid/ready pipeline stage around _5bit_xor, with parity of the held result
// and a running XOR checksum plus transfer count of every consumed result.
module _5bit_xor_stream
  import _5bit_xor_stream_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             parity,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] count
);

  state_t           state;
  logic [WIDTH-1:0] xor_out;
  logic             in_xfer;
  logic             out_xfer;

  _5bit_xor #(.WIDTH(WIDTH)) u_xor (
    .sum (xor_out),
    .a   (a),
    .b   (b)
  );

  assign out_valid = (state == FULL);
  // The slot can refill in the same cycle it drains, giving one result per cycle.
  assign in_ready  = (state == EMPTY) | out_ready;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign parity    = ^sum;

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let acc see the freshly loaded sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      sum   <= '0;
      acc   <= '0;
      count <= '0;
    end else begin
      if (in_xfer) begin
        state <= FULL;
        sum   <= xor_out;
      end else if (out_xfer) begin
        state <= EMPTY;
      end

      // A clear wins over accumulation; the result is still consumed by the FSM above.
      if (clear) begin
        acc   <= '0;
        count <= '0;
      end else if (out_xfer) begin
        acc   <= acc ^ sum;
        count <= count + 1'b1;
      end
    end
  end

endmodule
